// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, FSM encoding and the ReLU/shift/saturate helper
// used by the npcnn post-processing stages.
package cnn_pkg;
    localparam int PIX_W = 8;
    localparam int RES_W = 20;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [PIX_W-1:0] sat_u8(input logic signed [RES_W-1:0] x, input int unsigned shift);
        logic signed [RES_W-1:0] r;
        r = x[RES_W-1] ? '0 : x >>> shift;
        // r is non-negative here, so any bit above the pixel width means overflow
        return (|r[RES_W-1:PIX_W]) ? {PIX_W{1'b1}} : r[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/relu_quant.sv
// relu_quant: combinational ReLU, arithmetic right shift and unsigned 8-bit
// saturation of one signed result.
module relu_quant
    import cnn_pkg::*;
#(
    parameter int DW    = RES_W,
    parameter int SHIFT = 4
) (
    input  logic [DW-1:0]    data_i,
    output logic [PIX_W-1:0] pix_o
);
    if (DW > RES_W) begin : g_chk
        $error("relu_quant: DW must not exceed RES_W");
    end

    assign pix_o = sat_u8(RES_W'($signed(data_i)), SHIFT);
endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool: quantises each conv result, then max-pools the OSxOS raster frame
// in non-overlapping PWxPW windows into (OS/PW)^2 registered 8-bit pixels.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int OS    = 4,
    parameter int PW    = 2,
    parameter int DW    = 20,
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             done,
    output logic             busy
);
    localparam int NP  = OS / PW;
    localparam int CW  = $clog2(OS + 1);
    localparam int PCW = (NP > 1) ? $clog2(NP) : 1;

    if (PW < 1 || OS % PW != 0) begin : g_chk
        $error("relu_maxpool: OS must be a multiple of PW");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    row_q, row_d, col_q, col_d, cph, rph;
    logic [PIX_W-1:0] hmax_q, hmax_d, out_data_q, out_data_d;
    logic [PIX_W-1:0] q, m, lb_v, emit_v, lb_d;
    logic [PIX_W-1:0] lb_q [NP];
    logic [PCW-1:0]   pc;
    logic             out_valid_q, out_valid_d, done_q, done_d;
    logic             acc, start, last_col, last_row, emit, lb_we;

    relu_quant #(.DW(DW), .SHIFT(SHIFT)) u_quant (
        .data_i(in_data),
        .pix_o (q)
    );

    always_comb begin
        cph        = col_q % CW'(PW);
        rph        = row_q % CW'(PW);
        pc         = PCW'(col_q / CW'(PW));
        lb_v       = lb_q[pc];
        acc        = (state_q == RUN) && in_valid;
        // go is blind during the done cycle so a frame cannot restart on its own final pulse
        start      = (state_q == IDLE) && go && !done_q;
        last_col   = col_q == CW'(OS - 1);
        last_row   = row_q == CW'(OS - 1);
        m          = (cph != '0 && hmax_q > q) ? hmax_q : q;
        emit_v     = (PW > 1 && lb_v > m) ? lb_v : m;
        emit       = acc && cph == CW'(PW - 1) && rph == CW'(PW - 1);
        lb_we      = acc && PW > 1 && cph == CW'(PW - 1) && rph != CW'(PW - 1);
        lb_d       = (rph == '0) ? m : emit_v;
        hmax_d     = acc ? m : hmax_q;
        out_valid_d = emit;
        out_data_d = emit ? emit_v : out_data_q;
        done_d     = emit && last_row && last_col;
        state_d    = start ? RUN : state_q;
        row_d      = start ? '0 : row_q;
        col_d      = start ? '0 : col_q;
        if (acc) begin
            col_d   = last_col ? '0 : col_q + 1'b1;
            row_d   = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
            state_d = (last_col && last_row) ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            hmax_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < NP; i++) lb_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hmax_q      <= hmax_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            for (int i = 0; i < NP; i++) begin
                if (start) lb_q[i] <= '0;
                else if (lb_we && PCW'(i) == pc) lb_q[i] <= lb_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign busy      = state_q == RUN;
endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: frame table driven into relu_maxpool, expected pixels queued
// at drive time and matched against out_valid beats with exact cycle stamps.
module tb_relu_maxpool;
    localparam int OS = 4, PW = 2, DW = 20, SHIFT = 4;

    logic          clk = 1'b0, reset = 1'b1, go = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, done, busy;
    logic [7:0]    out_data;

    typedef struct { logic [7:0] v; logic d; int c; } exp_t;
    typedef struct { logic [15:0][19:0] d; logic [3:0][7:0] e; int gap; } frame_t;

    exp_t       sb[$];
    exp_t       mon_e;
    frame_t     fr[6];
    int         n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] last_out = '0;

    relu_maxpool #(.OS(OS), .PW(PW), .DW(DW), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .go(go), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] qz(input logic [19:0] d);
        int v;
        if (d[19]) return 8'd0;
        v = int'(d) >> SHIFT;
        return (v > 255) ? 8'd255 : v[7:0];
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                chk("out_valid has a queued expectation", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("out_data", out_data, mon_e.v);
                    chk("done with pixel", done, mon_e.d);
                    chk("output cycle", cyc, mon_e.c);
                end
                last_out = out_data;
            end else begin
                chk("done without out_valid", done, 0);
                chk("out_data hold", out_data, last_out);
            end
        end
    end

    task automatic start();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        chk("busy after go", busy, 1);
    endtask

    task automatic feed(input int f, input int n);
        for (int k = 0; k < n; k++) begin
            int g;
            g = (fr[f].gap > 0) ? int'($urandom_range(0, fr[f].gap)) : 0;
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_data  = fr[f].d[k];
            if ((k % 4) % 2 == 1 && (k / 4) % 2 == 1)
                sb.push_back('{fr[f].e[(k / 8) * 2 + (k % 4) / 2], k == 15, cyc + 1});
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk({name, " pending pixels"}, sb.size(), 0);
    endtask

    task automatic abort(input string name);
        #2 reset = 1'b0;
        #1;
        chk({name, " reset out_valid"}, out_valid, 0);
        chk({name, " reset done"}, done, 0);
        chk({name, " reset busy"}, busy, 0);
        chk({name, " reset out_data"}, out_data, 0);
        sb.delete();
        last_out = '0;
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d pixels pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            fr[0].d[k] = 20'(16 * k);
            fr[1].d[k] = 20'(-(k + 1));
            fr[2].d[k] = (k == 0) ? 20'h7FFFF : 20'd0;
            fr[4].d[k] = 20'($urandom_range(0, 9000)) - 20'd2000;
            fr[5].d[k] = 20'd159;
        end
        fr[0].e = {8'd15, 8'd13, 8'd7, 8'd5};
        fr[1].e = '0;
        fr[2].e = {8'd0, 8'd0, 8'd0, 8'd255};
        fr[5].e = {4{8'd9}};
        fr[0].gap = 0; fr[1].gap = 0; fr[2].gap = 0; fr[4].gap = 1; fr[5].gap = 0;
        fr[3] = fr[0];
        fr[3].gap = 3;
        for (int o = 0; o < 4; o++) begin
            logic [7:0] mx;
            mx = '0;
            for (int r = 2 * (o / 2); r < 2 * (o / 2) + 2; r++)
                for (int c = 2 * (o % 2); c < 2 * (o % 2) + 2; c++)
                    if (qz(fr[4].d[r * 4 + c]) > mx) mx = qz(fr[4].d[r * 4 + c]);
            fr[4].e[o] = mx;
        end

        #1 reset = 1'b0;
        #1;
        chk("init out_valid", out_valid, 0);
        chk("init done", done, 0);
        chk("init busy", busy, 0);
        chk("init out_data", out_data, 0);
        @(negedge clk) reset = 1'b1;

        start();
        feed(0, 16);
        chk("busy low on done cycle", busy, 0);
        drain("ramp");

        foreach (fr[i]) begin
            if (i == 1 || i == 2 || i == 5 || i == 3) begin
                start();
                feed(i, 16);
                drain($sformatf("frame%0d", i));
            end
        end

        repeat (3) begin
            in_valid = 1'b1;
            in_data  = 20'h7FFFF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("idle in_valid keeps busy low", busy, 0);

        start();
        feed(0, 16);
        go = 1'b1;
        @(negedge clk);
        chk("go in done cycle ignored", busy, 0);
        @(negedge clk);
        go = 1'b0;
        chk("go after done accepted", busy, 1);
        feed(4, 16);
        drain("back-to-back random");

        start();
        feed(0, 6);
        abort("mid-run");
        repeat (2) begin
            in_valid = 1'b1;
            in_data  = 20'h00100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("no restart without go", busy, 0);

        start();
        feed(0, 9);
        abort("abort after 9");
        start();
        feed(0, 16);
        drain("restart ramp");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
